// File: rtl/fu_mem_pipe_if.sv
// fu_mem_pipe_if: issue/result bus between an issuing core and the memory pipe
interface fu_mem_pipe_if #(
    parameter int TAG_W = 5
);
    logic             en;
    logic             ready;
    logic             mem_w;
    logic [2:0]       bhw;
    logic [31:0]      rs1_data;
    logic [31:0]      rs2_data;
    logic [31:0]      imm;
    logic [TAG_W-1:0] tag_in;
    logic             done;
    logic             done_ack;
    logic [TAG_W-1:0] tag_out;
    logic [31:0]      mem_data;
    logic             misaligned;

    modport master (
        output en, mem_w, bhw, rs1_data, rs2_data, imm, tag_in, done_ack,
        input  ready, done, tag_out, mem_data, misaligned
    );

    modport slave (
        input  en, mem_w, bhw, rs1_data, rs2_data, imm, tag_in, done_ack,
        output ready, done, tag_out, mem_data, misaligned
    );
endinterface

// File: rtl/fu_mem_pipe.sv
// fu_mem_pipe: in-order load/store unit, memory access one edge after accept, result after LATENCY edges
module fu_mem_pipe #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 5
) (
    input  logic         clk,
    input  logic         rst,
    fu_mem_pipe_if.slave bus
);
    localparam int AB = $clog2(DEPTH) + 2;

    logic [31:0]      mem_q [DEPTH];
    logic             v0_q;
    logic             w0_q;
    logic [2:0]       bhw0_q;
    logic [AB-1:0]    addr0_q;
    logic [AB-1:0]    addr_d;
    logic [31:0]      wd0_q;
    logic [TAG_W-1:0] tag0_q;
    logic [LATENCY:1] v_q;
    logic [LATENCY:1] mis_q;
    logic [TAG_W-1:0] tag_q [LATENCY:1];
    logic [31:0]      dat_q [LATENCY:1];
    logic             stall;
    logic             is_b;
    logic             is_h;
    logic             mis;
    logic             we;
    logic [AB-3:0]    idx;
    logic [31:0]      rd;
    logic [31:0]      sh;
    logic [31:0]      ld;
    logic [31:0]      res;
    logic [31:0]      wd;
    logic [3:0]       be;

    // a presented but unacknowledged result freezes every stage, including memory access
    assign stall     = v_q[LATENCY] && !bus.done_ack;
    assign bus.ready = !stall;
    // only the bits that select a word and lane are kept; higher address bits alias
    assign addr_d    = AB'(bus.rs1_data + bus.imm);

    assign is_b = bhw0_q[1:0] == 2'b00;
    assign is_h = bhw0_q[1:0] == 2'b01;
    assign mis  = is_h ? addr0_q[0] : (!is_b && addr0_q[1:0] != 2'b00);
    assign idx  = addr0_q[AB-1:2];
    assign rd   = mem_q[idx];
    assign sh   = rd >> {addr0_q[1:0], 3'b000};
    assign ld   = is_b ? {{24{sh[7] & ~bhw0_q[2]}}, sh[7:0]} :
                  is_h ? {{16{sh[15] & ~bhw0_q[2]}}, sh[15:0]} : rd;
    assign res  = (w0_q || mis) ? '0 : ld;
    assign be   = is_b ? 4'b0001 << addr0_q[1:0] : is_h ? (addr0_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wd   = is_b ? {4{wd0_q[7:0]}} : is_h ? {2{wd0_q[15:0]}} : wd0_q;
    // the write is deliberately not blocked by rst: a store reaching stage 1 always lands
    assign we   = v0_q && w0_q && !mis && !stall;

    // byte-lane memory write; contents survive reset
    always_ff @(posedge clk) begin
        if (we)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_q[idx][8*b +: 8] <= wd[8*b +: 8];
    end

    // stage valids: reset discards everything in flight, otherwise advance unless stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q <= 1'b0;
            v_q  <= '0;
        end else if (!stall) begin
            v0_q   <= bus.en;
            v_q[1] <= v0_q;
            for (int k = 2; k <= LATENCY; k++) v_q[k] <= v_q[k-1];
        end
    end

    // payload: capture the issue, then carry the stage-1 result down the pipe
    always_ff @(posedge clk) begin
        if (!stall) begin
            if (bus.en) begin
                w0_q    <= bus.mem_w;
                bhw0_q  <= bus.bhw;
                addr0_q <= addr_d;
                wd0_q   <= bus.rs2_data;
                tag0_q  <= bus.tag_in;
            end
            tag_q[1] <= tag0_q;
            dat_q[1] <= res;
            mis_q[1] <= mis;
            for (int k = 2; k <= LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
                dat_q[k] <= dat_q[k-1];
                mis_q[k] <= mis_q[k-1];
            end
        end
    end

    assign bus.done       = v_q[LATENCY];
    assign bus.tag_out    = bus.done ? tag_q[LATENCY] : '0;
    assign bus.mem_data   = bus.done ? dat_q[LATENCY] : '0;
    assign bus.misaligned = bus.done && mis_q[LATENCY];
endmodule

// File: tb/tb_fu_mem_pipe.sv
// tb_fu_mem_pipe: directed scoreboard bench for fu_mem_pipe (LATENCY=2 main unit, LATENCY=3 reset unit)
module tb_fu_mem_pipe;
    localparam int L = 2;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] data;
        logic        mis;
        int          acc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    bit   shown = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fu_mem_pipe_if #(.TAG_W(5)) a();
    fu_mem_pipe_if #(.TAG_W(5)) b();

    fu_mem_pipe #(.DEPTH(1024), .LATENCY(L), .TAG_W(5)) u_a (.clk(clk), .rst(rst_a), .bus(a));
    fu_mem_pipe #(.DEPTH(1024), .LATENCY(3), .TAG_W(5)) u_b (.clk(clk), .rst(rst_b), .bus(b));

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [2:0] bhw, input logic [31:0] rs1, input logic [31:0] imm,
                         input logic [31:0] rs2, input logic [4:0] tag, input logic [31:0] exp,
                         input logic mis, input bit lat);
        @(posedge clk);
        #2;
        a.en = 1'b1;
        a.mem_w = w;
        a.bhw = bhw;
        a.rs1_data = rs1;
        a.imm = imm;
        a.rs2_data = rs2;
        a.tag_in = tag;
        #1;
        for (int i = 0; i < 20 && !a.ready; i++) begin
            @(posedge clk);
            #3;
        end
        chk("issue_ready", a.ready, 1);
        q.push_back('{tag, exp, mis, cyc + 1, lat});
    endtask

    task automatic ld(input logic [2:0] bhw, input logic [31:0] rs1, input logic [31:0] imm,
                      input logic [4:0] tag, input logic [31:0] exp, input logic mis);
        issue(1'b0, bhw, rs1, imm, 32'h0, tag, exp, mis, 1'b1);
    endtask

    task automatic st(input logic [2:0] bhw, input logic [31:0] rs1, input logic [31:0] imm,
                      input logic [31:0] rs2, input logic [4:0] tag, input logic mis);
        issue(1'b1, bhw, rs1, imm, rs2, tag, 32'h0, mis, 1'b1);
    endtask

    task automatic idle();
        @(posedge clk);
        #2;
        a.en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain", q.size(), 0);
    endtask

    // scoreboard: compare the head entry whenever a result is presented, retire on ack
    always @(negedge clk) begin
        if (rst_a === 1'b0) begin
            if (!a.done) begin
                chk("idle_out", {a.tag_out, a.misaligned, a.mem_data}, 0);
            end else if (q.size() == 0) begin
                chk("spurious_done", a.done, 0);
            end else begin
                if (!shown && q[0].lat) chk("latency", cyc - q[0].acc, L);
                shown = 1'b1;
                chk("tag_out", a.tag_out, q[0].tag);
                chk("mem_data", a.mem_data, q[0].data);
                chk("misaligned", a.misaligned, q[0].mis);
                if (a.done_ack) begin
                    void'(q.pop_front());
                    shown = 1'b0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        a.en = 0; a.mem_w = 0; a.bhw = 0; a.rs1_data = 0; a.rs2_data = 0; a.imm = 0; a.tag_in = 0; a.done_ack = 1;
        b.en = 0; b.mem_w = 0; b.bhw = 0; b.rs1_data = 0; b.rs2_data = 0; b.imm = 0; b.tag_in = 0; b.done_ack = 1;
        repeat (2) @(posedge clk);
        #2;
        rst_a = 0;
        rst_b = 0;
        @(negedge clk);
        chk("rst_a_done", a.done, 0);
        chk("rst_a_ready", a.ready, 1);
        chk("rst_a_outs", {a.tag_out, a.misaligned, a.mem_data}, 0);
        chk("rst_b_done", b.done, 0);
        chk("rst_b_ready", b.ready, 1);

        st(3'b010, 32'h100, 32'h0, 32'h11223344, 5'd1, 1'b0);
        st(3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 5'd2, 1'b0);
        ld(3'b010, 32'h100, 32'h4, 5'd3, 32'hDEADBEEF, 1'b0);
        ld(3'b000, 32'h100, 32'h7, 5'd4, 32'hFFFFFFDE, 1'b0);
        ld(3'b100, 32'h100, 32'h7, 5'd5, 32'h000000DE, 1'b0);
        ld(3'b001, 32'h100, 32'h6, 5'd6, 32'hFFFFDEAD, 1'b0);
        ld(3'b101, 32'h100, 32'h4, 5'd7, 32'h0000BEEF, 1'b0);
        ld(3'b000, 32'h100, 32'h4, 5'd8, 32'hFFFFFFEF, 1'b0);
        ld(3'b010, 32'h100, 32'h2, 5'd9, 32'h0, 1'b1);
        st(3'b010, 32'h100, 32'h2, 32'hCAFEF00D, 5'd10, 1'b1);
        ld(3'b010, 32'h100, 32'h0, 5'd11, 32'h11223344, 1'b0);
        ld(3'b011, 32'h100, 32'h4, 5'd12, 32'hDEADBEEF, 1'b0);
        st(3'b001, 32'h100, 32'h1, 32'h0000BEEF, 5'd13, 1'b1);
        st(3'b000, 32'h100, 32'h1, 32'h777777AB, 5'd14, 1'b0);
        st(3'b001, 32'h100, 32'h2, 32'h99995566, 5'd15, 1'b0);
        ld(3'b010, 32'h100, 32'h0, 5'd16, 32'h5566AB44, 1'b0);
        ld(3'b010, 32'hFFFFFF00, 32'h200, 5'd17, 32'h5566AB44, 1'b0);
        ld(3'b010, 32'h1000, 32'h104, 5'd18, 32'hDEADBEEF, 1'b0);
        idle();
        drain();

        for (int t = 1; t <= 4; t++) ld(3'b010, 32'h100, 32'h4, 5'(t), 32'hDEADBEEF, 1'b0);
        idle();
        drain();

        a.done_ack = 0;
        issue(1'b1, 3'b010, 32'h200, 32'h0, 32'h0BADF00D, 5'd5, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 5'd6, 32'h0BADF00D, 1'b0, 1'b0);
        issue(1'b1, 3'b010, 32'h204, 32'h0, 32'h12345678, 5'd7, 32'h0, 1'b0, 1'b0);
        idle();
        repeat (3) begin
            @(negedge clk);
            chk("stall_ready", a.ready, 0);
            chk("stall_done", a.done, 1);
            chk("stall_tag", a.tag_out, 5);
        end
        @(posedge clk);
        #2;
        a.done_ack = 1;
        issue(1'b0, 3'b010, 32'h204, 32'h0, 32'h0, 5'd8, 32'h12345678, 1'b0, 1'b1);
        issue(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 5'd9, 32'h0BADF00D, 1'b0, 1'b1);
        idle();
        drain();

        issue(1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 5'd10, 32'h0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        rst_a = 1;
        q.delete();
        shown = 0;
        a.mem_w = 1;
        a.rs1_data = 32'h100;
        a.imm = 0;
        a.rs2_data = 32'hFFFFFFFF;
        @(posedge clk);
        #2;
        rst_a = 0;
        a.en = 0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_mid_done", a.done, 0);
            chk("rst_mid_ready", a.ready, 1);
        end
        ld(3'b010, 32'h100, 32'h0, 5'd11, 32'h5566AB44, 1'b0);
        idle();
        drain();

        @(posedge clk);
        #2;
        b.en = 1; b.mem_w = 1; b.bhw = 3'b010; b.rs1_data = 32'h300; b.imm = 0; b.rs2_data = 32'h600DCAFE; b.tag_in = 5'd3;
        @(posedge clk);
        #2;
        b.en = 0;
        rst_b = 1;
        @(posedge clk);
        #2;
        rst_b = 0;
        repeat (5) begin
            @(negedge clk);
            chk("b_no_done", b.done, 0);
        end
        @(posedge clk);
        #2;
        b.en = 1; b.mem_w = 0; b.tag_in = 5'd4;
        @(posedge clk);
        #2;
        b.en = 0;
        repeat (3) begin
            @(negedge clk);
            chk("b_wait", b.done, 0);
        end
        @(negedge clk);
        chk("b_done", b.done, 1);
        chk("b_tag", b.tag_out, 4);
        chk("b_data", b.mem_data, 32'h600DCAFE);
        @(negedge clk);
        chk("b_retired", b.done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fu_mem_pipe.md
FU_MEM_PIPE -- requirements
Module: fu_mem_pipe

Interface
REQ-001 Parameter DEPTH, default 1024, memory size in 32-bit words; power of two, >=4.
REQ-002 Parameter LATENCY, default 2, clock edges from accept to result; legal range 1..8.
REQ-003 Parameter TAG_W, default 5, width of the issue tag carried through the pipe.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 EN  input  1  issue valid.
REQ-007 ready  output  1  unit can accept an issue this cycle.
REQ-008 mem_w  input  1  1 = store, 0 = load.
REQ-009 bhw  input  3  bit2 = unsigned load, bits[1:0]: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-010 rs1_data, rs2_data, imm  input  32 each  base, store data, offset.
REQ-011 tag_in  input  TAG_W  issue tag.
REQ-012 done  output  1  result valid.
REQ-013 done_ack  input  1  consumer takes result this cycle.
REQ-014 tag_out  output  TAG_W  tag of completing op.
REQ-015 mem_data  output  32  load result (0 for stores).
REQ-016 misaligned  output  1  completing op was misaligned; qualified by done.

Function
REQ-017 Accept occurs at an edge where EN && ready; address = rs1_data + imm, mod 2^32.
REQ-018 Pipe holds up to LATENCY ops in flight, in-order; one accept per cycle max.
REQ-019 Op accepted at edge N shall present done=1 with its results after edge N+LATENCY, absent stalls.
REQ-020 Memory access for an op occurs at its first edge after accept (stage 1); each later stage adds one register.
REQ-021 Memory: byte-addressed little-endian; word index = addr[log2(DEPTH)+1:2]; upper address bits ignored (wrap modulo 4*DEPTH bytes).
REQ-022 Store byte writes rs2_data[7:0] to addressed lane; half writes rs2_data[15:0] to lanes addr[1]*2..+1; word writes all 4 lanes; other lanes unchanged.
REQ-023 Load byte/half sign-extends when bhw[2]=0, zero-extends when bhw[2]=1; word ignores bhw[2].
REQ-024 A load in stage 1 at the same edge a prior store is in stage 1 is impossible (in-order, one per stage); a load accepted one cycle after a store to the same word shall return the stored data.
REQ-025 Misaligned: half with addr[0]=1, word with addr[1:0]!=0; no memory write, mem_data=0, misaligned=1 on completion.
REQ-026 Stall: when done=1 and done_ack=0, all stages hold, ready=0, no accept, no memory access (a held store is never written twice).
REQ-027 ready = !(done && !done_ack); with done_ack=1 a new op may be accepted in the same cycle the result retires.
REQ-028 done, tag_out, mem_data, misaligned hold stable while done=1 and done_ack=0.
REQ-029 When done=0, mem_data, tag_out, misaligned shall be 0.
REQ-030 Stores complete with done=1, mem_data=0, tag_out = their tag.

Reset
REQ-031 rst at an edge clears all stage valids; after it done=0, ready=1, mem_data=0, tag_out=0, misaligned=0.
REQ-032 Reset mid-operation discards in-flight ops; stores already past stage 1 remain written; stores not yet at stage 1 are never written.
REQ-033 rst has priority over EN and done_ack at the same edge; memory contents are not cleared by rst (zero at simulation start).

Verification
REQ-034 Store word 0xDEADBEEF at rs1=0x100, imm=4, then load bhw=010 same address -> load done 2 edges after its accept, mem_data=0xDEADBEEF.
REQ-035 Load byte bhw=000 addr 0x107 after above -> 0xFFFFFFDE; bhw=100 -> 0x000000DE; half bhw=001 addr 0x106 -> 0xFFFFDEAD.
REQ-036 Back-to-back 4 loads, tags 1..4, done_ack tied 1 -> done high 4 consecutive cycles, tag_out 1,2,3,4 in order.
REQ-037 done_ack held 0 for 3 cycles with 2 ops in flight -> ready=0, outputs frozen, then tags retire in order, no duplicate store.
REQ-038 Word load at addr 0x102 -> misaligned=1, mem_data=0; word store at 0x102 -> memory unchanged.
REQ-039 rst asserted one cycle after a store accept with LATENCY=3 -> done never asserts for it; store visible to later load (already at stage 1).
